grb_pixel_source: RTL

//  Upstream pixel generator for the WS2812B send path. On each frame request it

---
 rtl/grb_pixel_source.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/grb_pixel_source.sv
// grb_pixel_source: per-frame GRB pixel generator for the WS2812B send path.
// Emits one 24-bit {G,R,B} word per LED, in LED order, over a valid/req handshake.
// Modes: solid, animated rainbow, single-pixel chase, off.
// Optional build macro BRIGHTNESS_EN: right-shift each colour byte by `bright`.
//
// Handshake: grb_valid rises when a pixel is registered into grb_out and stays
// high, with grb_out stable, until pixel_req is seen high on a rising edge.
// That edge consumes the pixel and grb_valid falls; pixel_req has no effect
// while grb_valid is low. grb_out keeps its last value between pixels.
module grb_pixel_source #(
    parameter logic [7:0] HUE_STEP   = 8'd8,
    parameter logic [7:0] FRAME_STEP = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [3:0]  num_leds,
    input  logic [1:0]  mode,
    input  logic [23:0] base_grb,
    input  logic [2:0]  bright,
    input  logic        pixel_req,
    output logic [23:0] grb_out,
    output logic        grb_valid,
    output logic        last_pixel,
    output logic        frame_busy,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SOLID   = 2'b00;
    localparam logic [1:0] MODE_RAINBOW = 2'b01;
    localparam logic [1:0] MODE_CHASE   = 2'b10;

    state_t      stateQ;
    state_t      stateD;
    logic        startFrame;
    logic        takePixel;
    logic        lastIdx;

    logic [3:0]  idx;
    logic [3:0]  numLat;
    logic [1:0]  modeLat;
    logic [23:0] baseLat;
    logic [7:0]  frameHue;
    logic [3:0]  chasePos;

    logic [7:0]  hue;
    logic [7:0]  hueK;
    logic [7:0]  wheelG;
    logic [7:0]  wheelR;
    logic [7:0]  wheelB;
    logic [23:0] pixRaw;
    logic [23:0] pixScaled;

    // 3*v in 8 bits; callers only pass v < 86 so the result never overflows.
    function automatic logic [7:0] times3(input logic [7:0] v);
        return {v[6:0], 1'b0} + v;
    endfunction

    assign lastIdx    = (idx == (numLat - 4'd1));
    assign last_pixel = grb_valid && lastIdx;
    assign dbgState   = stateQ;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic plus the one-cycle frame-accept and pixel-take strobes.
    always_comb begin
        stateD     = stateQ;
        startFrame = 1'b0;
        takePixel  = 1'b0;
        case (stateQ)
            IDLE: begin
                if (frame_start && (num_leds != 4'd0)) begin
                    startFrame = 1'b1;
                    stateD     = CALC;
                end
            end
            CALC: begin
                stateD = HOLD;
            end
            HOLD: begin
                if (pixel_req) begin
                    takePixel = 1'b1;
                    stateD    = lastIdx ? IDLE : CALC;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Colour of the current pixel from the frame's latched settings.
    always_comb begin
        hue    = frameHue + ({4'd0, idx} * HUE_STEP);
        hueK   = 8'd0;
        wheelG = 8'd0;
        wheelR = 8'd0;
        wheelB = 8'd0;
        if (hue < 8'd85) begin
            wheelR = 8'd255 - times3(hue);
            wheelG = times3(hue);
        end else if (hue < 8'd170) begin
            hueK   = hue - 8'd85;
            wheelG = 8'd255 - times3(hueK);
            wheelB = times3(hueK);
        end else begin
            hueK   = hue - 8'd170;
            wheelB = 8'd255 - times3(hueK);
            wheelR = times3(hueK);
        end

        case (modeLat)
            MODE_SOLID:   pixRaw = baseLat;
            MODE_RAINBOW: pixRaw = {wheelG, wheelR, wheelB};
            MODE_CHASE:   pixRaw = (idx == chasePos) ? baseLat : 24'h0;
            default:      pixRaw = 24'h0;
        endcase
    end

`ifdef BRIGHTNESS_EN
    // Per-byte logical right shift; bright=0 leaves the colour unchanged.
    always_comb begin
        pixScaled = {pixRaw[23:16] >> bright, pixRaw[15:8] >> bright, pixRaw[7:0] >> bright};
    end
`else
    logic unusedBright;
    assign unusedBright = ^bright;
    // Unscaled build: colour passes straight through.
    always_comb begin
        pixScaled = pixRaw;
    end
`endif

    // Frame latches, pixel output register and per-frame animation state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= 4'd0;
            numLat     <= 4'd0;
            modeLat    <= 2'd0;
            baseLat    <= 24'h0;
            frameHue   <= 8'd0;
            chasePos   <= 4'd0;
            grb_out    <= 24'h0;
            grb_valid  <= 1'b0;
            frame_busy <= 1'b0;
        end else begin
            if (startFrame) begin
                numLat     <= num_leds;
                modeLat    <= mode;
                baseLat    <= base_grb;
                idx        <= 4'd0;
                frame_busy <= 1'b1;
                // A shorter frame than last time may leave chasePos out of range.
                chasePos   <= chasePos % num_leds;
            end
            if (stateQ == CALC) begin
                grb_out   <= pixScaled;
                grb_valid <= 1'b1;
            end
            if (takePixel) begin
                grb_valid <= 1'b0;
                if (lastIdx) begin
                    frame_busy <= 1'b0;
                    frameHue   <= frameHue + FRAME_STEP;
                    chasePos   <= (chasePos == (numLat - 4'd1)) ? 4'd0 : (chasePos + 4'd1);
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

endmodule
